// File: rtl/mem_stack_pkg.sv
// Shared encodings for the memory/stack responder: RAM write-data select,
// flag bit positions and sticky stack-fault bit indices.
package mem_stack_pkg;

  typedef enum logic [1:0] {
    RAMIN_MBR   = 2'b00,
    RAMIN_FLAGS = 2'b01,
    RAMIN_PCH   = 2'b10,
    RAMIN_PCL   = 2'b11
  } ram_in_e;

  localparam int unsigned FLAG_ZERO  = 3;
  localparam int unsigned FLAG_SIGN  = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_CARRY = 0;

  localparam int unsigned FAULT_OVF = 1;
  localparam int unsigned FAULT_UDF = 0;

  // RAM write-data mux; CALL frames push FLAGS, PCH, PCL in that order.
  function automatic logic [7:0] ram_wdata_sel(input logic [1:0] sel,
                                               input logic [7:0] mbr,
                                               input logic [3:0] flags,
                                               input logic [15:0] pc);
    logic [7:0] d;
    d = mbr;
    case (sel)
      RAMIN_MBR:   d = mbr;
      RAMIN_FLAGS: d = {4'b0000, flags};
      RAMIN_PCH:   d = pc[15:8];
      RAMIN_PCL:   d = pc[7:0];
      default:     d = mbr;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stack_unit_sp_counter.sv
// Hardware stack pointer: bounded inc/dec, full/empty decode and sticky
// overflow/underflow flags. SP saturates at the bounds instead of wrapping.
module sp_counter
  import mem_stack_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_BASE  = 'hC0,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inc,
  input  logic              dec,
  input  logic              wr,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic [1:0]        fault,
  output logic              push_ok
);

  localparam logic [ADDR_W-1:0] SP_BASE = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] SP_TOP  = ADDR_W'(STACK_BASE + STACK_DEPTH);

  logic [ADDR_W-1:0] sp_d;
  logic [1:0]        fault_set;

  assign empty   = (sp == SP_BASE);
  assign full    = (sp == SP_TOP);
  assign push_ok = en & inc & wr & ~dec & ~full;

  // Simultaneous inc+dec is a CU protocol error: flag both faults, hold SP.
  always_comb begin
    sp_d      = sp;
    fault_set = 2'b00;
    if (en && inc && dec) begin
      fault_set = 2'b11;
    end else if (en && dec) begin
      if (empty) fault_set[FAULT_UDF] = 1'b1;
      else       sp_d = sp - ADDR_W'(1);
    end else if (en && inc && wr) begin
      if (full) fault_set[FAULT_OVF] = 1'b1;
      else      sp_d = sp + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= SP_BASE;
      fault <= 2'b00;
    end else begin
      sp    <= sp_d;
      fault <= fault | fault_set;
    end
  end

endmodule

// File: rtl/mem_stack_unit.sv
// Memory-side responder for the control unit: MAR, MBR, unified RAM and the
// hardware stack, driven directly by the CU strobes each cycle.
module mem_stack_unit
  import mem_stack_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_BASE  = 'hC0,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic              CU_clk,
  input  logic              CU_rst,
  input  logic              MAR_we,
  input  logic              MAR_mux,
  input  logic              MBR_we,
  input  logic              MBR_mux,
  input  logic              RAM_we,
  input  logic [1:0]        RAM_in,
  input  logic              SP_en,
  input  logic              SP_inc,
  input  logic              SP_dec,
  input  logic [15:0]       PC,
  input  logic [15:0]       FG,
  input  logic [7:0]        Reg_data,
  input  logic [3:0]        Flags,
  input  logic              LD_we,
  input  logic [ADDR_W-1:0] LD_addr,
  input  logic [7:0]        LD_data,
  output logic [7:0]        MBR_out,
  output logic [ADDR_W-1:0] SP_out,
  output logic              Stack_empty,
  output logic              Stack_full,
  output logic [1:0]        Stack_fault
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_W;

  logic [7:0]        ram [RAM_DEPTH];
  logic [ADDR_W-1:0] mar_q;
  logic [7:0]        mbr_q;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic [7:0]        ram_wdata;
  logic              push_ok;
  logic              cu_wr;
  logic              unused_fg_hi;

  assign unused_fg_hi = ^FG[15:ADDR_W];

  sp_counter #(
    .ADDR_W      (ADDR_W),
    .STACK_BASE  (STACK_BASE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_sp (
    .clk     (CU_clk),
    .rst     (CU_rst),
    .en      (SP_en),
    .inc     (SP_inc),
    .dec     (SP_dec),
    .wr      (RAM_we),
    .sp      (sp),
    .full    (Stack_full),
    .empty   (Stack_empty),
    .fault   (Stack_fault),
    .push_ok (push_ok)
  );

  assign ram_addr  = SP_en ? sp : mar_q;
  assign ram_rdata = ram[ram_addr];
  assign ram_wdata = ram_wdata_sel(RAM_in, mbr_q, Flags, PC);

  // Stack-addressed writes with SP_inc only land when the push is legal.
  assign cu_wr = RAM_we & ~(SP_en & SP_inc & ~push_ok);

  // Loader owns the write port whenever it is active.
  always_ff @(posedge CU_clk) begin
    if (LD_we)      ram[LD_addr]  <= LD_data;
    else if (cu_wr) ram[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge CU_clk or posedge CU_rst) begin
    if (CU_rst) begin
      mar_q <= '0;
      mbr_q <= '0;
    end else begin
      if (MAR_we) mar_q <= MAR_mux ? FG[ADDR_W-1:0] : PC[ADDR_W-1:0];
      if (MBR_we) mbr_q <= MBR_mux ? Reg_data : ram_rdata;
    end
  end

  assign MBR_out = mbr_q;
  assign SP_out  = sp;

endmodule

// File: tb/tb_mem_stack_unit.sv
// Self-checking bench for mem_stack_unit: directed scenarios plus a random
// push/pop walk against a queue-based stack model.
module tb_mem_stack_unit;

  localparam int unsigned BASE  = 'hC0;
  localparam int unsigned DEPTH = 32;

  logic        CU_clk = 1'b0;
  logic        CU_rst;
  logic        MAR_we, MAR_mux, MBR_we, MBR_mux, RAM_we;
  logic [1:0]  RAM_in;
  logic        SP_en, SP_inc, SP_dec;
  logic [15:0] PC, FG;
  logic [7:0]  Reg_data;
  logic [3:0]  Flags;
  logic        LD_we;
  logic [7:0]  LD_addr, LD_data;
  logic [7:0]  MBR_out, SP_out;
  logic        Stack_empty, Stack_full;
  logic [1:0]  Stack_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0] mram [256];
  logic [7:0] stk [$];
  logic       m_ovf, m_udf;
  logic [7:0] m_mbr;

  mem_stack_unit dut (
    .CU_clk(CU_clk), .CU_rst(CU_rst),
    .MAR_we(MAR_we), .MAR_mux(MAR_mux), .MBR_we(MBR_we), .MBR_mux(MBR_mux),
    .RAM_we(RAM_we), .RAM_in(RAM_in),
    .SP_en(SP_en), .SP_inc(SP_inc), .SP_dec(SP_dec),
    .PC(PC), .FG(FG), .Reg_data(Reg_data), .Flags(Flags),
    .LD_we(LD_we), .LD_addr(LD_addr), .LD_data(LD_data),
    .MBR_out(MBR_out), .SP_out(SP_out),
    .Stack_empty(Stack_empty), .Stack_full(Stack_full), .Stack_fault(Stack_fault)
  );

  always #5 CU_clk = ~CU_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] frame_byte(input logic [1:0] sel, input logic [7:0] mbr,
                                            input logic [3:0] fl, input logic [15:0] pc);
    case (sel)
      2'd0:    return mbr;
      2'd1:    return {4'b0000, fl};
      2'd2:    return pc[15:8];
      default: return pc[7:0];
    endcase
  endfunction

  function automatic logic [7:0] exp_sp();
    return 8'(BASE + stk.size());
  endfunction

  task automatic tick();
    @(posedge CU_clk);
    #1;
  endtask

  task automatic clr();
    MAR_we = 0; MAR_mux = 0; MBR_we = 0; MBR_mux = 0; RAM_we = 0; RAM_in = 0;
    SP_en = 0; SP_inc = 0; SP_dec = 0; LD_we = 0;
  endtask

  task automatic do_reset();
    clr();
    @(negedge CU_clk);
    CU_rst = 1;
    @(negedge CU_clk);
    CU_rst = 0;
    stk.delete();
    m_ovf = 0; m_udf = 0; m_mbr = 8'h00;
  endtask

  task automatic ld_write(input logic [7:0] a, input logic [7:0] d);
    LD_we = 1; LD_addr = a; LD_data = d;
    tick();
    LD_we = 0;
    mram[a] = d;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
    clr();
    MAR_mux = 1; FG = {8'h00, a}; MAR_we = 1;
    tick();
    MAR_we = 0; MBR_mux = 0; MBR_we = 1;
    tick();
    clr();
    d = MBR_out;
    m_mbr = mram[a];
  endtask

  task automatic push(input logic [1:0] sel);
    logic [7:0] data;
    data = frame_byte(sel, m_mbr, Flags, PC);
    SP_en = 1; SP_inc = 1; RAM_we = 1; RAM_in = sel;
    tick();
    clr();
    if (stk.size() < DEPTH) begin
      mram[exp_sp()] = data;
      stk.push_back(data);
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic pop(output logic [7:0] d, output logic [7:0] e);
    SP_en = 1; SP_dec = 1;
    tick();
    SP_dec = 0; MBR_mux = 0; MBR_we = 1;
    tick();
    clr();
    d = MBR_out;
    if (stk.size() == 0) begin
      m_udf = 1;
      e = mram[BASE];
    end else begin
      e = stk.pop_back();
    end
    m_mbr = e;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (SP_out !== 8'hC0) begin bad++; $display("FAIL reset_sp got=%h want=c0", SP_out); end
    total++; if (MBR_out !== 8'h00) begin bad++; $display("FAIL reset_mbr got=%h want=00", MBR_out); end
    total++; if (Stack_fault !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b want=00", Stack_fault); end
    total++; if (Stack_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", Stack_empty); end
    total++; if (Stack_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", Stack_full); end
  endtask

  task automatic test_fetch();
    ld_write(8'h05, 8'h4A);
    PC = 16'h0005; MAR_mux = 0; MAR_we = 1;
    tick();
    MAR_we = 0; MBR_mux = 0; MBR_we = 1;
    tick();
    clr();
    total++; if (MBR_out !== 8'h4A) begin bad++; $display("FAIL fetch got=%h want=4a", MBR_out); end
  endtask

  task automatic test_mov_m();
    logic [7:0] d;
    FG = 16'h0030; Reg_data = 8'h77; MAR_mux = 1; MAR_we = 1;
    tick();
    MAR_we = 0; MBR_mux = 1; MBR_we = 1;
    tick();
    MBR_we = 0; MBR_mux = 0; RAM_we = 1; RAM_in = 2'b00;
    tick();
    clr();
    mram[8'h30] = 8'h77;
    total++; if (MBR_out !== 8'h77) begin bad++; $display("FAIL movm_mbr got=%h want=77", MBR_out); end
    read_mem(8'h30, d);
    total++; if (d !== 8'h77) begin bad++; $display("FAIL movm_ram got=%h want=77", d); end
  endtask

  task automatic test_same_addr();
    logic [7:0] d;
    ld_write(8'h40, 8'h11);
    FG = 16'h0040; MAR_mux = 1; MAR_we = 1;
    tick();
    MAR_we = 0; Reg_data = 8'h22; MBR_mux = 1; MBR_we = 1;
    tick();
    MBR_mux = 0; MBR_we = 1; RAM_we = 1; RAM_in = 2'b00;
    tick();
    clr();
    mram[8'h40] = 8'h22;
    total++; if (MBR_out !== 8'h11) begin bad++; $display("FAIL rdw_old got=%h want=11", MBR_out); end
    read_mem(8'h40, d);
    total++; if (d !== 8'h22) begin bad++; $display("FAIL rdw_new got=%h want=22", d); end
  endtask

  task automatic test_call_frame();
    logic [7:0] d;
    do_reset();
    Flags = 4'b1010; PC = 16'h12AB;
    push(2'b01); push(2'b10); push(2'b11);
    total++; if (SP_out !== 8'hC3) begin bad++; $display("FAIL call_sp got=%h want=c3", SP_out); end
    read_mem(8'hC0, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL call_c0 got=%h want=0a", d); end
    read_mem(8'hC1, d);
    total++; if (d !== 8'h12) begin bad++; $display("FAIL call_c1 got=%h want=12", d); end
    read_mem(8'hC2, d);
    total++; if (d !== 8'hAB) begin bad++; $display("FAIL call_c2 got=%h want=ab", d); end
  endtask

  task automatic test_return();
    logic [7:0] d, e;
    logic [7:0] want [3];
    want[0] = 8'hAB; want[1] = 8'h12; want[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      pop(d, e);
      total++; if (d !== want[i] || d !== e) begin bad++; $display("FAIL ret_pop%0d got=%h want=%h", i, d, want[i]); end
    end
    total++; if (SP_out !== 8'hC0) begin bad++; $display("FAIL ret_sp got=%h want=c0", SP_out); end
    total++; if (Stack_empty !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b want=1", Stack_empty); end
    total++; if (Stack_fault !== 2'b00) begin bad++; $display("FAIL ret_fault got=%b want=00", Stack_fault); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    do_reset();
    ld_write(8'hE0, 8'h5A);
    for (int i = 0; i < 33; i++) begin
      PC = 16'(i + 16'h0100);
      if (i == 32) begin
        total++; if (Stack_full !== 1'b1 || SP_out !== 8'hE0) begin bad++; $display("FAIL ovf_full32 got=%b/%h want=1/e0", Stack_full, SP_out); end
      end
      push(2'b11);
    end
    total++; if (SP_out !== 8'hE0) begin bad++; $display("FAIL ovf_sp got=%h want=e0", SP_out); end
    total++; if (Stack_fault !== 2'b10) begin bad++; $display("FAIL ovf_fault got=%b want=10", Stack_fault); end
    read_mem(8'hE0, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL ovf_e0 got=%h want=5a", d); end
    read_mem(8'hDF, d);
    total++; if (d !== mram[8'hDF]) begin bad++; $display("FAIL ovf_df got=%h want=%h", d, mram[8'hDF]); end
  endtask

  task automatic test_underflow();
    logic [7:0] d, e;
    do_reset();
    pop(d, e);
    total++; if (SP_out !== 8'hC0) begin bad++; $display("FAIL udf_sp got=%h want=c0", SP_out); end
    total++; if (Stack_fault !== 2'b01) begin bad++; $display("FAIL udf_fault got=%b want=01", Stack_fault); end
    total++; if (d !== e) begin bad++; $display("FAIL udf_mbr got=%h want=%h", d, e); end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    do_reset();
    ld_write(8'hC0, 8'h3C);
    Flags = 4'h5; SP_en = 1; SP_inc = 1; SP_dec = 1; RAM_we = 1; RAM_in = 2'b01;
    tick();
    clr();
    total++; if (SP_out !== 8'hC0) begin bad++; $display("FAIL conf_sp got=%h want=c0", SP_out); end
    total++; if (Stack_fault !== 2'b11) begin bad++; $display("FAIL conf_fault got=%b want=11", Stack_fault); end
    read_mem(8'hC0, d);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL conf_nowrite got=%h want=3c", d); end
  endtask

  task automatic test_loader_priority();
    logic [7:0] d;
    do_reset();
    ld_write(8'hC0, 8'h66);
    Flags = 4'hF;
    SP_en = 1; SP_inc = 1; RAM_we = 1; RAM_in = 2'b01;
    LD_we = 1; LD_addr = 8'h50; LD_data = 8'h99;
    tick();
    clr();
    mram[8'h50] = 8'h99;
    total++; if (SP_out !== 8'hC1) begin bad++; $display("FAIL ldp_sp got=%h want=c1", SP_out); end
    total++; if (Stack_fault !== 2'b00) begin bad++; $display("FAIL ldp_fault got=%b want=00", Stack_fault); end
    read_mem(8'hC0, d);
    total++; if (d !== 8'h66) begin bad++; $display("FAIL ldp_drop got=%h want=66", d); end
    read_mem(8'h50, d);
    total++; if (d !== 8'h99) begin bad++; $display("FAIL ldp_load got=%h want=99", d); end
  endtask

  task automatic test_random_stack();
    logic [7:0] d, e;
    logic [11:0] want, got;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      Flags = 4'($urandom);
      PC    = 16'($urandom);
      case ($urandom_range(0, 4))
        0, 1: push(2'($urandom_range(0, 3)));
        2: begin
          pop(d, e);
          total++; if (d !== e) begin bad++; $display("FAIL rnd_pop step=%0d got=%h want=%h", i, d, e); end
        end
        3: begin
          SP_dec = 1;
          tick();
          clr();
        end
        default: begin
          SP_en = 1; SP_inc = 1;
          tick();
          clr();
        end
      endcase
      want = {exp_sp(), m_ovf, m_udf, stk.size() == 0, stk.size() == DEPTH};
      got  = {SP_out, Stack_fault, Stack_empty, Stack_full};
      total++; if (got !== want) begin bad++; $display("FAIL rnd_state step=%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d, e;
    do_reset();
    ld_write(8'h00, 8'h5C);
    ld_write(8'h30, 8'hE7);
    pop(d, e);
    read_mem(8'h30, d);
    Flags = 4'b0110; PC = 16'h3456;
    push(2'b01); push(2'b10);
    #2;
    CU_rst = 1;
    #1;
    total++; if (SP_out !== 8'hC0) begin bad++; $display("FAIL rst_async_sp got=%h want=c0", SP_out); end
    total++; if (MBR_out !== 8'h00) begin bad++; $display("FAIL rst_async_mbr got=%h want=00", MBR_out); end
    total++; if (Stack_fault !== 2'b00) begin bad++; $display("FAIL rst_async_fault got=%b want=00", Stack_fault); end
    @(negedge CU_clk);
    CU_rst = 0;
    stk.delete(); m_ovf = 0; m_udf = 0; m_mbr = 8'h00;
    MBR_we = 1; MBR_mux = 0;
    tick();
    clr();
    total++; if (MBR_out !== 8'h5C) begin bad++; $display("FAIL rst_mar got=%h want=5c", MBR_out); end
    read_mem(8'hC0, d);
    total++; if (d !== 8'h06) begin bad++; $display("FAIL rst_keep_c0 got=%h want=06", d); end
    read_mem(8'hC1, d);
    total++; if (d !== 8'h34) begin bad++; $display("FAIL rst_keep_c1 got=%h want=34", d); end
  endtask

  initial begin
    CU_rst = 1;
    clr();
    PC = 16'h0000; FG = 16'h0000; Reg_data = 8'h00; Flags = 4'h0;
    LD_addr = 8'h00; LD_data = 8'h00;
    for (int i = 0; i < 256; i++) mram[i] = 8'h00;
    test_reset();
    for (int i = 0; i < 256; i++) ld_write(8'(i), 8'(i * 7 + 3));
    test_fetch();
    test_mov_m();
    test_same_addr();
    test_call_frame();
    test_return();
    test_overflow();
    test_underflow();
    test_conflict();
    test_loader_priority();
    test_random_stack();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
